serial_tx_sched: RTL and testbench
==================================

# serial_tx_sched

Scheduler that shares one parallel-to-serial shift path between two word producers. It arbitrates round-robin between two valid/ready requesters and loads the granted word. It then shifts the word out LSB-first, one bit per cycle, with frame markers. It sits between the word-producing logic and the single-bit serial output, and takes over the load and shift sequencing that producers otherwise drive by hand from a free-running counter.

## Interface
- WIDTH, 4: bits per word and serial frame length in cycles; must be at least 2.
- GAP, 0: idle cycles inserted after each frame before the next word may be accepted; range 0–15.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 presents a word.
- req0_data  in  WIDTH  requester 0 word.
- req0_ready  out  1  requester 0 word accepted this cycle when valid is also high.
- req1_valid, req1_data, req1_ready: same roles for requester 1.
- ser_out  out  1  current serial bit; 0 whenever ser_valid is low.
- ser_valid  out  1  ser_out carries a frame bit.
- ser_first  out  1  high with bit 0 of a frame.
- ser_last  out  1  high with bit WIDTH-1 of a frame.
- ser_src  out  1  source requester of the current frame; held after the frame ends.
- busy  out  1  high in SHIFT or GAP.

## Operation
- States:
  - IDLE: no frame in progress.
  - SHIFT: a frame is being shifted out.
  - GAP: post-frame idle cycles, counted by gap_cnt.
- A transfer occurs when reqN_valid and reqN_ready are both high at a rising edge.
- Valid rule: once a requester raises valid, it holds valid and data stable until it is accepted.
- Grant is combinational from the valids and the last_grant pointer:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester that is not last_grant is granted.
  - last_grant resets to 1, so req0 wins the first tie.
  - last_grant updates only on a transfer.
- reqN_ready is high only when requester N is granted and the block is in an accept slot.
- Accept slots:
  - the IDLE state;
  - the SHIFT cycle with ser_last high, when GAP==0.
- On a transfer:
  - shreg <= data; bit_cnt <= 0; ser_src <= granted index; state <= SHIFT.
- In SHIFT, each cycle:
  - ser_out = shreg[0] and ser_valid = 1.
  - At the edge, shreg shifts right with zero fill and bit_cnt increments.
  - ser_first = (bit_cnt == 0); ser_last = (bit_cnt == WIDTH-1).
- Exit from the ser_last cycle:
  - If a transfer occurs in that cycle, reload and stay in SHIFT. Frames are back-to-back with no bubble.
  - Else if GAP > 0, go to GAP with gap_cnt = GAP-1.
  - Else go to IDLE.
- GAP:
  - All ready outputs are low.
  - gap_cnt decrements each cycle; when it reaches 0, go to IDLE.
- bit_cnt width is $clog2(WIDTH); no wrap occurs beyond WIDTH-1 because the frame terminates.
- Reset, including reset mid-frame:
  - state = IDLE; shreg, bit_cnt and gap_cnt = 0; last_grant = 1; ser_src = 0.
  - All outputs are 0.
  - Any in-flight word is discarded; the requester is not re-informed.

## Timing
- Accept edge to first serial bit: 1 cycle. ser_valid rises in the cycle following the transfer edge.
- Frame length: exactly WIDTH consecutive ser_valid cycles.
- Throughput:
  - GAP==0 with continuous demand: one word per WIDTH cycles.
  - From IDLE: WIDTH+1 cycles per word.
  - Otherwise: WIDTH+GAP+1 cycles per word.
- ready is combinational from valid and state. valid must not depend combinationally on ready.
- All outputs except reqN_ready are registered or decoded from registered state only.

## Structure
- Shared package holds:
  - the state enum: IDLE, SHIFT, GAP;
  - requester index constants REQ0=0 and REQ1=1;
  - a default-width constant of 4.
- One sub-module, shift_out_reg: a WIDTH-bit load/shift register with ld, sh, d and out.
- The FSM, round-robin arbiter, bit counter and gap counter stay in serial_tx_sched.

## Test plan
- Single word (GAP=0): req0 sends 4'b1011 from IDLE → ser_out 1,1,0,1 in the 4 cycles after the accept. ser_first on the 1st bit, ser_last on the 4th, ser_src=0, then IDLE with busy=0.
- Tie and round-robin: both requesters hold valid continuously, req0 with 4'hA and req1 with 4'h5 → frames back-to-back in source order 0,1,0,1. Bits read 0,1,0,1 then 1,0,1,0, with no bubble between frames.
- Busy backpressure: req1 raises valid with 4'h3 during a req0 frame → req1_ready stays low until req0's ser_last cycle. It is accepted there, and the next frame starts the following cycle.
- GAP=2: two queued words → exactly 2 cycles with ser_valid=0 and both ready low between frames, then 1 accept cycle in IDLE.
- Reset mid-frame: assert rst after bit 1 of a frame → all outputs 0 immediately (asynchronous). After release, a tie grants req0 first.
- Single requester repeating: only req1 valid for three words → all three granted to req1 with ser_src=1; last_grant does not block a sole requester.

Source files
------------

// File: rtl/serial_tx_sched_pkg.sv
// Shared types and constants for the two-requester serial transmit scheduler.
package serial_tx_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam logic REQ0      = 1'b0;
  localparam logic REQ1      = 1'b1;
  localparam int   DEF_WIDTH = 4;

endpackage

// File: rtl/serial_tx_sched_if.sv
// Requester handshakes plus serial output bundle; master = producer side, slave = scheduler.
interface serial_tx_sched_if import serial_tx_sched_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_first;
  logic             ser_last;
  logic             ser_src;
  logic             busy;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, ser_out, ser_valid, ser_first, ser_last, ser_src, busy
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, ser_out, ser_valid, ser_first, ser_last, ser_src, busy
  );
endinterface

// File: rtl/serial_tx_sched_shift_out_reg.sv
// WIDTH-bit load/shift register, LSB out; load wins over shift, zero fill from the top.
// Latency: loaded word's bit 0 appears on out the cycle after ld; no backpressure.
module shift_out_reg import serial_tx_sched_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             sh,
  input  logic [WIDTH-1:0] d,
  output logic             out
);
  logic [WIDTH-1:0] shreg_q, shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (ld) begin
      shreg_d = d;
    end else if (sh) begin
      shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign out = shreg_q[0];
endmodule

// File: rtl/serial_tx_sched.sv
// Round-robin scheduler feeding two requesters' words into one LSB-first serial frame path.
// Latency: first bit one cycle after accept; ready only in IDLE or a GAP==0 last-bit cycle.
module serial_tx_sched import serial_tx_sched_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GAP   = 0
) (
  input logic              clk,
  input logic              rst,
  serial_tx_sched_if.slave bus
);
  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);
  localparam logic [3:0]      GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_e        state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [3:0]    gap_cnt_q, gap_cnt_d;
  logic          last_grant_q, last_grant_d;
  logic          ser_src_q, ser_src_d;

  logic             shreg_out;
  logic             is_last;
  logic             accept_slot;
  logic             grant1;
  logic             xfer;
  logic [WIDTH-1:0] load_dat;

  assign is_last     = (state_q == ST_SHIFT) && (bit_cnt_q == LAST_BIT);
  // Ready is forced low during reset so every output reads 0 while rst is high.
  assign accept_slot = !rst && ((state_q == ST_IDLE) || (is_last && (GAP == 0)));
  assign grant1      = bus.req1_valid && (!bus.req0_valid || (last_grant_q == REQ0));
  assign xfer        = accept_slot && (bus.req0_valid || bus.req1_valid);
  assign load_dat    = grant1 ? bus.req1_data : bus.req0_data;

  assign bus.req0_ready = accept_slot && bus.req0_valid && !grant1;
  assign bus.req1_ready = accept_slot && grant1;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    last_grant_d = last_grant_q;
    ser_src_d    = ser_src_q;
    if (xfer) begin
      state_d      = ST_SHIFT;
      bit_cnt_d    = '0;
      last_grant_d = grant1;
      ser_src_d    = grant1;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (is_last) begin
            if (GAP > 0) begin
              state_d   = ST_GAP;
              gap_cnt_d = GAP_LOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      last_grant_q <= REQ1;
      ser_src_q    <= REQ0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      last_grant_q <= last_grant_d;
      ser_src_q    <= ser_src_d;
    end
  end

  shift_out_reg #(.WIDTH(WIDTH)) u_shift (
    .clk (clk),
    .rst (rst),
    .ld  (xfer),
    .sh  (state_q == ST_SHIFT),
    .d   (load_dat),
    .out (shreg_out)
  );

  assign bus.ser_valid = (state_q == ST_SHIFT);
  assign bus.ser_out   = bus.ser_valid && shreg_out;
  assign bus.ser_first = bus.ser_valid && (bit_cnt_q == '0);
  assign bus.ser_last  = is_last;
  assign bus.ser_src   = ser_src_q;
  assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_serial_tx_sched.sv
// Random two-requester traffic into GAP=0 and GAP=2 schedulers, checked cycle by cycle
// against a timeline model: accept slots, frame bit positions and busy windows by arithmetic.
module tb_serial_tx_sched;
  import serial_tx_sched_pkg::*;

  localparam int W    = 4;
  localparam int NCYC = 1600;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_tx_sched_if #(.WIDTH(W)) bus0 ();
  serial_tx_sched_if #(.WIDTH(W)) bus1 ();

  serial_tx_sched #(.WIDTH(W), .GAP(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  serial_tx_sched #(.WIDTH(W), .GAP(2)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  logic         vld [2][2];
  logic [W-1:0] dat [2][2];
  logic [7:0]   obs [2];

  assign bus0.req0_valid = vld[0][0];
  assign bus0.req0_data  = dat[0][0];
  assign bus0.req1_valid = vld[0][1];
  assign bus0.req1_data  = dat[0][1];
  assign bus1.req0_valid = vld[1][0];
  assign bus1.req0_data  = dat[1][0];
  assign bus1.req1_valid = vld[1][1];
  assign bus1.req1_data  = dat[1][1];

  assign obs[0] = {bus0.req0_ready, bus0.req1_ready, bus0.ser_valid, bus0.ser_out,
                   bus0.ser_first, bus0.ser_last, bus0.ser_src, bus0.busy};
  assign obs[1] = {bus1.req0_ready, bus1.req1_ready, bus1.ser_valid, bus1.ser_out,
                   bus1.ser_first, bus1.ser_last, bus1.ser_src, bus1.busy};

  string fname [8] = '{"req0_ready", "req1_ready", "ser_valid", "ser_out",
                       "ser_first", "ser_last", "ser_src", "busy"};

  // Timeline model: a word accepted in cycle a is on the wire in cycles a+1..a+W.
  int           gap_of [2] = '{0, 2};
  int           next_ok [2];
  int           last_acc [2];
  logic         lg [2];
  logic         src_held [2];
  logic [W-1:0] cur_dat [2];
  logic         acc_pend [2];
  logic         acc_src [2];
  logic [W-1:0] acc_dat [2];

  int   t;
  int   n_vec = 0;
  int   n_mis = 0;
  logic rst_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      next_ok[i]  = t;
      last_acc[i] = -1000;
      lg[i]       = 1'b1;
      src_held[i] = 1'b0;
      cur_dat[i]  = '0;
      acc_pend[i] = 1'b0;
      acc_src[i]  = 1'b0;
      acc_dat[i]  = '0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < 2; i++)
      for (int b = 0; b < 8; b++)
        chk($sformatf("%s d%0d %s", tag, i, fname[b]), 32'(obs[i][7-b]), 32'd0);
  endtask

  task automatic check_cycle();
    for (int i = 0; i < 2; i++) begin
      logic       g0, g1, slot, sv, bitv;
      int         k;
      logic [7:0] e;
      slot = (t >= next_ok[i]);
      g0   = vld[i][0] && (!vld[i][1] || lg[i]);
      g1   = vld[i][1] && !g0;
      k    = t - last_acc[i] - 1;
      sv   = (k >= 0) && (k < W);
      bitv = 1'b0;
      if (sv) bitv = cur_dat[i][k];
      e = {slot && g0, slot && g1, sv, bitv, sv && (k == 0), sv && (k == W-1), src_held[i],
           (t > last_acc[i]) && (t <= last_acc[i] + W + gap_of[i])};
      for (int b = 0; b < 8; b++)
        chk($sformatf("d%0d %s t=%0d", i, fname[b], t), 32'(obs[i][7-b]), 32'(e[7-b]));
      acc_pend[i] = slot && (g0 || g1);
      acc_src[i]  = g1;
      acc_dat[i]  = g1 ? dat[i][1] : dat[i][0];
    end
  endtask

  task automatic edge_update();
    for (int i = 0; i < 2; i++) begin
      if (acc_pend[i]) begin
        last_acc[i]         = t;
        cur_dat[i]          = acc_dat[i];
        src_held[i]         = acc_src[i];
        lg[i]               = acc_src[i];
        next_ok[i]          = t + W + ((gap_of[i] > 0) ? gap_of[i] + 1 : 0);
        vld[i][acc_src[i]]  = 1'b0;
        acc_pend[i]         = 1'b0;
      end
    end
    t++;
  endtask

  task automatic drive_producers();
    int p [2];
    if (t < 200)      begin p[0] = 100; p[1] = 100; end
    else if (t < 700) begin p[0] = 50;  p[1] = 50;  end
    else if (t < 900) begin p[0] = 0;   p[1] = 100; end
    else              begin p[0] = 30;  p[1] = 60;  end
    for (int i = 0; i < 2; i++)
      for (int n = 0; n < 2; n++)
        if (!vld[i][n] && ($urandom_range(99) < 32'(p[n]))) begin
          vld[i][n] = 1'b1;
          dat[i][n] = W'($urandom);
        end
  endtask

  // Asynchronous reset in the middle of a frame, with a tie pending on both requesters.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 chk_all_zero("midrst");
    for (int i = 0; i < 2; i++)
      for (int n = 0; n < 2; n++)
        if (!vld[i][n]) begin
          vld[i][n] = 1'b1;
          dat[i][n] = W'($urandom);
        end
    @(posedge clk);
    #1 rst = 1'b0;
    t++;
    model_reset();
    rst_done = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      for (int n = 0; n < 2; n++) begin
        vld[i][n] = 1'b0;
        dat[i][n] = '0;
      end
    t = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    rst = 1'b0;
    model_reset();
    drive_producers();
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      check_cycle();
      if (!rst_done && (t >= 400) && (last_acc[0] == t - 2)) begin
        do_reset();
      end else begin
        @(posedge clk);
        #1 edge_update();
      end
      drive_producers();
    end
    chk("midrst_seen", 32'(rst_done), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
